// File: rtl/snake_vga_renderer.sv
// Raster scanner for the snake game's 20x20 board: 640x480@60Hz timing,
// tear-free per-frame snapshot of the grid, and a two-stage pixel pipeline to the DAC pins.
module snake_vga_renderer #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CELL_PX  = 24,
    parameter int X_OFFSET = 80
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [19:0][19:0]  display_array,
    input  logic               gameover,
    output logic               hsync,
    output logic               vsync,
    output logic [3:0]         red,
    output logic [3:0]         green,
    output logic [3:0]         blue,
    output logic               frame_start
);
    localparam int GRID = 20;
    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] X_START  = 10'(X_OFFSET);
    localparam logic [9:0] X_END    = 10'(X_OFFSET + GRID * CELL_PX);
    localparam logic [4:0] SUB_LAST = 5'(CELL_PX - 1);
    localparam logic [4:0] CELL_LAST = 5'(GRID - 1);

    logic [9:0]        h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [4:0]        sub_x_q, sub_x_d, cell_x_q, cell_x_d;
    logic [4:0]        sub_y_q, sub_y_d, cell_y_q, cell_y_d;
    logic [19:0][19:0] snapshot_q, snapshot_d;
    logic              go_snap_q, go_snap_d;

    logic              s1_active_q, s1_active_d, s1_grid_q, s1_grid_d;
    logic              s1_edge_q, s1_edge_d, s1_origin_q, s1_origin_d;
    logic              s1_hsync_q, s1_hsync_d, s1_vsync_q, s1_vsync_d;
    logic [4:0]        s1_cell_x_q, s1_cell_x_d, s1_cell_y_q, s1_cell_y_d;

    logic              hsync_q, hsync_d, vsync_q, vsync_d, frame_start_q, frame_start_d;
    logic [11:0]       rgb_q, rgb_d;

    // Cell position is tracked incrementally; cell indices saturate past the grid so they stay in range.
    always_comb begin
        h_cnt_d  = h_cnt_q + 10'd1;
        v_cnt_d  = v_cnt_q;
        sub_x_d  = sub_x_q;
        cell_x_d = cell_x_q;
        sub_y_d  = sub_y_q;
        cell_y_d = cell_y_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d  = '0;
            sub_x_d  = '0;
            cell_x_d = '0;
            if (v_cnt_q == V_LAST) begin
                v_cnt_d  = '0;
                sub_y_d  = '0;
                cell_y_d = '0;
            end else begin
                v_cnt_d = v_cnt_q + 10'd1;
                if (v_cnt_q < V_ACT) begin
                    if (sub_y_q == SUB_LAST) begin
                        sub_y_d = '0;
                        if (cell_y_q < CELL_LAST) cell_y_d = cell_y_q + 5'd1;
                    end else begin
                        sub_y_d = sub_y_q + 5'd1;
                    end
                end
            end
        end else if (h_cnt_q >= X_START) begin
            if (sub_x_q == SUB_LAST) begin
                sub_x_d = '0;
                if (cell_x_q < CELL_LAST) cell_x_d = cell_x_q + 5'd1;
            end else begin
                sub_x_d = sub_x_q + 5'd1;
            end
        end
    end

    always_comb begin
        snapshot_d = snapshot_q;
        go_snap_d  = go_snap_q;
        if (h_cnt_q == 10'd0 && v_cnt_q == V_ACT) begin
            snapshot_d = display_array;
            go_snap_d  = gameover;
        end
    end

    always_comb begin
        s1_active_d = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        s1_grid_d   = s1_active_d && (h_cnt_q >= X_START) && (h_cnt_q < X_END);
        s1_edge_d   = (sub_x_q == 5'd0) || (sub_y_q == 5'd0);
        s1_cell_x_d = cell_x_q;
        s1_cell_y_d = cell_y_q;
        s1_hsync_d  = !((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
        s1_vsync_d  = !((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
        s1_origin_d = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
    end

    always_comb begin
        rgb_d = 12'h000;
        if (!s1_active_q)
            rgb_d = 12'h000;
        else if (!s1_grid_q)
            rgb_d = 12'h444;
        else if (snapshot_q[s1_cell_y_q][s1_cell_x_q])
            rgb_d = go_snap_q ? 12'hF00 : 12'h0F0;
        else if (s1_edge_q)
            rgb_d = 12'h002;
        hsync_d       = s1_hsync_q;
        vsync_d       = s1_vsync_q;
        frame_start_d = s1_origin_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            sub_x_q       <= '0;
            cell_x_q      <= '0;
            sub_y_q       <= '0;
            cell_y_q      <= '0;
            snapshot_q    <= '0;
            go_snap_q     <= 1'b0;
            s1_active_q   <= 1'b0;
            s1_grid_q     <= 1'b0;
            s1_edge_q     <= 1'b0;
            s1_cell_x_q   <= '0;
            s1_cell_y_q   <= '0;
            s1_hsync_q    <= 1'b1;
            s1_vsync_q    <= 1'b1;
            s1_origin_q   <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            rgb_q         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            sub_x_q       <= sub_x_d;
            cell_x_q      <= cell_x_d;
            sub_y_q       <= sub_y_d;
            cell_y_q      <= cell_y_d;
            snapshot_q    <= snapshot_d;
            go_snap_q     <= go_snap_d;
            s1_active_q   <= s1_active_d;
            s1_grid_q     <= s1_grid_d;
            s1_edge_q     <= s1_edge_d;
            s1_cell_x_q   <= s1_cell_x_d;
            s1_cell_y_q   <= s1_cell_y_d;
            s1_hsync_q    <= s1_hsync_d;
            s1_vsync_q    <= s1_vsync_d;
            s1_origin_q   <= s1_origin_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            rgb_q         <= rgb_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign red         = rgb_q[11:8];
    assign green       = rgb_q[7:4];
    assign blue        = rgb_q[3:0];
    assign frame_start = frame_start_q;
endmodule
